// File: rtl/stim_pkg.sv
// -----------------------------------------------------------------------------
// stim_pkg
// Shared definitions for the stimulus driver: default vector widths, the bit
// layout of a STIM_FIFO word and the driver state encoding.
//
// STIM_FIFO word layout (SFD_WIDTH = 30 bits by default):
//   [29:6] input_vector   applied to the DUT input pins
//   [5:1]  cycle_info     settle cycles (mode 0) or clock pulses (mode 1)
//   [0]    mode_select    0 = combinational DUT, 1 = sequential DUT
// -----------------------------------------------------------------------------
package stim_pkg;

   localparam int STF_WIDTH   = 24;
   localparam int CYCLE_RANGE = 5;
   localparam int SFD_WIDTH   = STF_WIDTH + CYCLE_RANGE + 1;

   localparam int VEC_LSB  = 6;
   localparam int CYC_LSB  = 1;
   localparam int MODE_BIT = 0;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_LOAD,
      S_SETTLE,
      S_CLK_HI,
      S_CLK_LO,
      S_SAMPLE,
      S_WRITE
   } state_t;

endpackage

// File: rtl/stim_driver_timer.sv
// -----------------------------------------------------------------------------
// stim_driver_timer
// Loadable down-counter that paces the settle window or the number of DUT
// clock pulses for one stimulus vector.
//
// Ports:
//   clock       in   system clock
//   reset_n     in   asynchronous, active-low reset (count returns to 0)
//   load        in   load load_value into the counter (wins over dec)
//   load_value  in   WIDTH  value to load
//   dec         in   decrement the counter by one
//   at_one      out  count is exactly 1 (last settle cycle / last pulse)
// -----------------------------------------------------------------------------
module stim_driver_timer #(
   parameter int WIDTH = stim_pkg::CYCLE_RANGE
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             dec,
   output logic             at_one
);

   logic [WIDTH-1:0] cnt;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_value;
      end else if (dec) begin
         cnt <= cnt - WIDTH'(1);
      end
   end

   assign at_one = (cnt == WIDTH'(1));

endmodule

// File: rtl/stim_driver.sv
// -----------------------------------------------------------------------------
// stim_driver
// Read-side consumer of STIM_FIFO. For every entry it pops, it drives the
// input vector onto the DUT, then either waits a settle time (mode 0) or
// pulses the DUT clock (mode 1), samples the DUT outputs and pushes the
// captured word into RESULT_FIFO.
//
// Ports:
//   clock          in   system clock
//   reset_n        in   asynchronous, active-low reset
//   enable         in   permit fetching new vectors
//   busy           out  high whenever the driver is not idle
//   sfifo_data     in   SFD_WIDTH  STIM_FIFO q (normal mode, valid after rdreq)
//   sfifo_rdreq    out  STIM_FIFO read request
//   sfifo_rdempty  in   STIM_FIFO empty
//   dut_in         out  STF_WIDTH  DUT input pins (held until next vector)
//   dut_clk        out  generated DUT clock
//   dut_out        in   STF_WIDTH  DUT output pins (already synchronised)
//   rfifo_data     out  STF_WIDTH  captured DUT outputs
//   rfifo_wrreq    out  RESULT_FIFO write request
//   rfifo_wrfull   in   RESULT_FIFO full
//   vec_count      out  16-bit count of accepted result writes, present only
//                       when STIM_DRIVER_VCOUNT_EN is defined
// -----------------------------------------------------------------------------
module stim_driver #(
   parameter int STF_WIDTH   = stim_pkg::STF_WIDTH,
   parameter int CYCLE_RANGE = stim_pkg::CYCLE_RANGE,
   parameter int SFD_WIDTH   = STF_WIDTH + CYCLE_RANGE + 1
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 enable,
   output logic                 busy,
   input  logic [SFD_WIDTH-1:0] sfifo_data,
   output logic                 sfifo_rdreq,
   input  logic                 sfifo_rdempty,
   output logic [STF_WIDTH-1:0] dut_in,
   output logic                 dut_clk,
   input  logic [STF_WIDTH-1:0] dut_out,
   output logic [STF_WIDTH-1:0] rfifo_data,
   output logic                 rfifo_wrreq,
   input  logic                 rfifo_wrfull
`ifdef STIM_DRIVER_VCOUNT_EN
   ,
   output logic [15:0]          vec_count
`endif
);

   import stim_pkg::*;

   state_t                 state;
   logic [CYCLE_RANGE-1:0] cyc_field;
   logic                   mode_field;
   logic [CYCLE_RANGE-1:0] load_value;
   logic                   timer_load;
   logic                   timer_dec;
   logic                   timer_at_one;

   assign cyc_field  = sfifo_data[CYC_LSB +: CYCLE_RANGE];
   assign mode_field = sfifo_data[MODE_BIT];

   // A zero cycle count still gives one settle cycle / one clock pulse.
   assign load_value = (cyc_field == '0) ? CYCLE_RANGE'(1) : cyc_field;
   assign timer_load = (state == S_LOAD);
   assign timer_dec  = ((state == S_SETTLE) || (state == S_CLK_LO)) && !timer_at_one;

   assign busy = (state != S_IDLE);

   // The write strobe is gated by the live full flag so that a full
   // RESULT_FIFO can never see a write, even in the cycle it turns full.
   assign rfifo_wrreq = (state == S_WRITE) && !rfifo_wrfull;

   stim_driver_timer #(
      .WIDTH (CYCLE_RANGE)
   ) u_timer (
      .clock      (clock),
      .reset_n    (reset_n),
      .load       (timer_load),
      .load_value (load_value),
      .dec        (timer_dec),
      .at_one     (timer_at_one)
   );

   // NOTE: all state and registered outputs use non-blocking assignments so
   // every register samples pre-edge values, independent of statement order.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state       <= S_IDLE;
         dut_in      <= '0;
         dut_clk     <= 1'b0;
         rfifo_data  <= '0;
         sfifo_rdreq <= 1'b0;
      end else begin
         // Single-cycle strobes default low; only the transitions below raise them.
         sfifo_rdreq <= 1'b0;
         dut_clk     <= 1'b0;
         case (state)
            S_IDLE: begin
               if (enable && !sfifo_rdempty) begin
                  state       <= S_FETCH;
                  sfifo_rdreq <= 1'b1;
               end
            end
            // q of a normal-mode FIFO appears the cycle after rdreq.
            S_FETCH: state <= S_LOAD;
            S_LOAD: begin
               dut_in <= sfifo_data[VEC_LSB +: STF_WIDTH];
               if (mode_field) begin
                  state   <= S_CLK_HI;
                  dut_clk <= 1'b1;
               end else begin
                  state <= S_SETTLE;
               end
            end
            S_SETTLE: begin
               if (timer_at_one) state <= S_SAMPLE;
            end
            S_CLK_HI: state <= S_CLK_LO;
            S_CLK_LO: begin
               if (timer_at_one) begin
                  state <= S_SAMPLE;
               end else begin
                  state   <= S_CLK_HI;
                  dut_clk <= 1'b1;
               end
            end
            S_SAMPLE: begin
               rfifo_data <= dut_out;
               state      <= S_WRITE;
            end
            S_WRITE: begin
               if (!rfifo_wrfull) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef STIM_DRIVER_VCOUNT_EN
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         vec_count <= '0;
      end else if (rfifo_wrreq) begin
         vec_count <= vec_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_stim_driver.sv
// -----------------------------------------------------------------------------
// tb_stim_driver
// Directed bench for stim_driver. A small STIM_FIFO model (normal mode) feeds
// the driver; the DUT output pins are either looped back from dut_in or driven
// by an 8-bit counter clocked by dut_clk. Latencies are counted in negedges
// from the step that made an entry available.
// -----------------------------------------------------------------------------
module tb_stim_driver;

   localparam int W  = 24;
   localparam int CR = 5;
   localparam int SW = W + CR + 1;

   logic          clock        = 1'b0;
   logic          reset_n      = 1'b0;
   logic          enable       = 1'b0;
   logic          rfifo_wrfull = 1'b0;
   logic [SW-1:0] sfifo_data   = '0;
   logic          busy;
   logic          sfifo_rdreq;
   logic          sfifo_rdempty;
   logic [W-1:0]  dut_in;
   logic          dut_clk;
   logic [W-1:0]  dut_out;
   logic [W-1:0]  rfifo_data;
   logic          rfifo_wrreq;
`ifdef STIM_DRIVER_VCOUNT_EN
   logic [15:0]   vec_count;
`endif

   logic          out_sel    = 1'b0;
   logic [7:0]    pulse_cnt  = '0;
   logic [7:0]    pulse_base = '0;
   logic [SW-1:0] mem [16];
   int            pushed_n    = 0;
   int            popped_n    = 0;
   int            rdreq_count = 0;
   int            wr_count    = 0;
   int            viol        = 0;
   int            clk_viol    = 0;
   logic          last_hi     = 1'b0;
   int            n_asserts   = 0;
   int            n_fail      = 0;

   always #5 clock = ~clock;

   stim_driver dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .enable        (enable),
      .busy          (busy),
      .sfifo_data    (sfifo_data),
      .sfifo_rdreq   (sfifo_rdreq),
      .sfifo_rdempty (sfifo_rdempty),
      .dut_in        (dut_in),
      .dut_clk       (dut_clk),
      .dut_out       (dut_out),
      .rfifo_data    (rfifo_data),
      .rfifo_wrreq   (rfifo_wrreq),
      .rfifo_wrfull  (rfifo_wrfull)
`ifdef STIM_DRIVER_VCOUNT_EN
      ,
      .vec_count     (vec_count)
`endif
   );

   // STIM_FIFO model: q updates the cycle after an accepted rdreq.
   assign sfifo_rdempty = (pushed_n == popped_n);

   always @(posedge clock) begin
      if (sfifo_rdreq && !sfifo_rdempty) begin
         sfifo_data <= mem[popped_n[3:0]];
         popped_n   <= popped_n + 1;
      end
      if (sfifo_rdreq) rdreq_count <= rdreq_count + 1;
      if (rfifo_wrreq) wr_count <= wr_count + 1;
      if ((sfifo_rdreq && sfifo_rdempty) || (rfifo_wrreq && rfifo_wrfull)) viol <= viol + 1;
   end

   // dut_clk must never be high on two consecutive system cycles.
   always @(negedge clock) begin
      if (dut_clk && last_hi) clk_viol <= clk_viol + 1;
      last_hi <= dut_clk;
   end

   always @(posedge dut_clk) pulse_cnt <= pulse_cnt + 8'd1;

   assign dut_out = out_sel ? {16'h0000, 8'(pulse_cnt - pulse_base)} : dut_in;

   function automatic logic [SW-1:0] mk(input logic [W-1:0] vec, input logic [CR-1:0] cyc,
                                        input logic mode);
      return {vec, cyc, mode};
   endfunction

   task automatic push(input logic [SW-1:0] entry);
      mem[pushed_n[3:0]] = entry;
      pushed_n = pushed_n + 1;
   endtask

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_asserts++;
      assert (observed === expected) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Returns the number of negedges until rfifo_wrreq is seen, or -1.
   task automatic wait_wrreq(input int budget, output int n);
      n = -1;
      for (int i = 1; i <= budget; i++) begin
         @(negedge clock);
         if (rfifo_wrreq === 1'b1) begin
            n = i;
            break;
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int rd0;
      int wr0;
      int changes;

      // Reset state
      repeat (2) @(negedge clock);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_rdreq", 32'(sfifo_rdreq), 32'd0);
      check("rst_wrreq", 32'(rfifo_wrreq), 32'd0);
      check("rst_dut_clk", 32'(dut_clk), 32'd0);
      check("rst_dut_in", 32'(dut_in), 32'd0);
      check("rst_rfifo_data", 32'(rfifo_data), 32'd0);
      reset_n = 1'b1;

      // Mode 0, cyc=3, loopback: step through fetch/load by hand
      push(mk(24'hA5A5A5, 5'd3, 1'b0));
      @(negedge clock);
      check("idle_without_enable", 32'(busy), 32'd0);
      enable = 1'b1;
      @(negedge clock);
      check("fetch_busy", 32'(busy), 32'd1);
      check("fetch_rdreq", 32'(sfifo_rdreq), 32'd1);
      @(negedge clock);
      check("load_rdreq_low", 32'(sfifo_rdreq), 32'd0);
      check("load_dut_in_old", 32'(dut_in), 32'd0);
      @(negedge clock);
      check("m0_dut_in", 32'(dut_in), 32'hA5A5A5);
      wait_wrreq(20, n);
      check("m0_c3_latency", 32'(n), 32'd4);
      check("m0_c3_data", 32'(rfifo_data), 32'hA5A5A5);
      @(negedge clock);
      check("m0_wrreq_one_cycle", 32'(rfifo_wrreq), 32'd0);
      check("m0_idle_after", 32'(busy), 32'd0);

      // Mode 1, cyc=4, counter on dut_clk
      pulse_base = pulse_cnt;
      out_sel = 1'b1;
      push(mk(24'h123456, 5'd4, 1'b1));
      wait_wrreq(40, n);
      check("m1_c4_latency", 32'(n), 32'd12);
      check("m1_c4_data", 32'(rfifo_data), 32'd4);
      check("m1_c4_pulses", 32'(8'(pulse_cnt - pulse_base)), 32'd4);
      check("m1_dut_in", 32'(dut_in), 32'h123456);
      @(negedge clock);
      out_sel = 1'b0;

      // cyc=0 mode 0 followed back-to-back by cyc=1 mode 0
      pulse_base = pulse_cnt;
      push(mk(24'h00FF00, 5'd0, 1'b0));
      push(mk(24'h00F00F, 5'd1, 1'b0));
      wait_wrreq(20, n);
      check("m0_c0_latency", 32'(n), 32'd5);
      check("m0_c0_data", 32'(rfifo_data), 32'h00FF00);
      wait_wrreq(20, n);
      check("m0_c1_back_to_back", 32'(n), 32'd6);
      check("m0_c1_data", 32'(rfifo_data), 32'h00F00F);
      check("m0_no_pulses", 32'(8'(pulse_cnt - pulse_base)), 32'd0);
      @(negedge clock);

      // cyc=0 mode 1: exactly one pulse
      pulse_base = pulse_cnt;
      out_sel = 1'b1;
      push(mk(24'h777777, 5'd0, 1'b1));
      wait_wrreq(20, n);
      check("m1_c0_latency", 32'(n), 32'd6);
      check("m1_c0_data", 32'(rfifo_data), 32'd1);
      check("m1_c0_pulses", 32'(8'(pulse_cnt - pulse_base)), 32'd1);
      @(negedge clock);
      out_sel = 1'b0;

      // RESULT_FIFO full for 10 cycles while in WRITE
      rfifo_wrfull = 1'b1;
      rd0 = rdreq_count;
      wr0 = wr_count;
      push(mk(24'h3C3C3C, 5'd1, 1'b0));
      push(mk(24'h0F0F0F, 5'd2, 1'b0));
      repeat (5) @(negedge clock);
      check("full_in_write_busy", 32'(busy), 32'd1);
      check("full_no_wrreq", 32'(rfifo_wrreq), 32'd0);
      check("full_data", 32'(rfifo_data), 32'h3C3C3C);
      changes = 0;
      repeat (10) begin
         @(negedge clock);
         if (rfifo_data !== 24'h3C3C3C || rfifo_wrreq !== 1'b0) changes++;
      end
      check("full_hold_glitches", 32'(changes), 32'd0);
      check("full_rdreq_count", 32'(rdreq_count - rd0), 32'd1);
      check("full_write_count", 32'(wr_count - wr0), 32'd0);
      rfifo_wrfull = 1'b0;
      #1;
      check("release_wrreq", 32'(rfifo_wrreq), 32'd1);
      wait_wrreq(20, n);
      check("after_release_latency", 32'(n), 32'd7);
      check("after_release_data", 32'(rfifo_data), 32'h0F0F0F);
      check("release_single_write", 32'(wr_count - wr0), 32'd1);
      @(negedge clock);
      check("full_total_writes", 32'(wr_count - wr0), 32'd2);
      check("full_total_rdreq", 32'(rdreq_count - rd0), 32'd2);

      // Three entries, enable dropped during the second vector's SETTLE
      rd0 = rdreq_count;
      push(mk(24'h111111, 5'd3, 1'b0));
      push(mk(24'h222222, 5'd3, 1'b0));
      push(mk(24'h333333, 5'd3, 1'b1));
      wait_wrreq(30, n);
      check("q1_latency", 32'(n), 32'd7);
      check("q1_data", 32'(rfifo_data), 32'h111111);
      repeat (4) @(negedge clock);
      check("q2_settle_dut_in", 32'(dut_in), 32'h222222);
      enable = 1'b0;
      wait_wrreq(30, n);
      check("q2_completes", 32'(n), 32'd4);
      check("q2_data", 32'(rfifo_data), 32'h222222);
      repeat (10) @(negedge clock);
      check("disabled_idle", 32'(busy), 32'd0);
      check("disabled_rdreq_count", 32'(rdreq_count - rd0), 32'd2);

      // Async reset while in CLK_HI
      enable = 1'b1;
      repeat (3) @(negedge clock);
      check("clk_hi_dut_clk", 32'(dut_clk), 32'd1);
      check("clk_hi_dut_in", 32'(dut_in), 32'h333333);
      reset_n = 1'b0;
      #1;
      check("arst_dut_clk", 32'(dut_clk), 32'd0);
      check("arst_dut_in", 32'(dut_in), 32'd0);
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_rdreq", 32'(sfifo_rdreq), 32'd0);
      check("arst_wrreq", 32'(rfifo_wrreq), 32'd0);
      check("arst_rfifo_data", 32'(rfifo_data), 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      check("arst_entry_discarded", 32'(busy), 32'd0);
      push(mk(24'h5A5A5A, 5'd2, 1'b0));
      wait_wrreq(20, n);
      check("post_rst_latency", 32'(n), 32'd6);
      check("post_rst_data", 32'(rfifo_data), 32'h5A5A5A);
      @(negedge clock);
      check("post_rst_idle", 32'(busy), 32'd0);

      // Global protocol and bookkeeping
      check("total_writes", 32'(wr_count), 32'd10);
      check("strobe_protocol", 32'(viol), 32'd0);
      check("dut_clk_shape", 32'(clk_viol), 32'd0);
`ifdef STIM_DRIVER_VCOUNT_EN
      check("vec_count", 32'(vec_count), 32'd1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
